// File: rtl/clk_pkg.sv
// Shared constants, field widths and hour conversion for the real-time clock core.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package clk_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [SEC_W-1:0]  SEC_MAX    = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_MAX    = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR24_MAX = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR12_MAX = 5'd12;

  // 12h display hour plus PM flag to internal 0..23 hour (12 AM -> 0, 12 PM -> 12).
  function automatic logic [HOUR_W-1:0] hour12_to_24(input logic [HOUR_W-1:0] hour12,
                                                     input logic              pm);
    logic [HOUR_W-1:0] base;
    base = hour12 % HOUR12_MAX;
    return base + (pm ? HOUR12_MAX : 5'd0);
  endfunction

endpackage

// File: rtl/digital_clk_cfg_if.sv
// Control/status bundle between the clock core and its user (display driver, sounder, CPU).
// Latency: n/a (wires only).
// Backpressure: none; inputs are sampled every cycle, outputs are level or one-cycle pulses.
// Ports: run/mode/set/alarm controls in, display time plus tick/day_wrap/set_err/alarm pulses out.
interface digital_clk_cfg_if;
  import clk_pkg::*;

  logic              run_i;
  logic              mode_24h_i;
  logic              set_i;
  logic [HOUR_W-1:0] set_hour_i;
  logic              set_pm_i;
  logic [MIN_W-1:0]  set_min_i;
  logic [SEC_W-1:0]  set_sec_i;
  logic              alarm_en_i;
  logic [HOUR_W-1:0] alarm_hour_i;
  logic [MIN_W-1:0]  alarm_min_i;

  logic [HOUR_W-1:0] hour_o;
  logic              pm_o;
  logic [MIN_W-1:0]  min_o;
  logic [SEC_W-1:0]  sec_o;
  logic              tick_o;
  logic              day_wrap_o;
  logic              set_err_o;
  logic              alarm_o;

  modport master (
    output run_i, mode_24h_i, set_i, set_hour_i, set_pm_i, set_min_i, set_sec_i,
           alarm_en_i, alarm_hour_i, alarm_min_i,
    input  hour_o, pm_o, min_o, sec_o, tick_o, day_wrap_o, set_err_o, alarm_o
  );

  modport slave (
    input  run_i, mode_24h_i, set_i, set_hour_i, set_pm_i, set_min_i, set_sec_i,
           alarm_en_i, alarm_hour_i, alarm_min_i,
    output hour_o, pm_o, min_o, sec_o, tick_o, day_wrap_o, set_err_o, alarm_o
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk_i by TICK_DIV into a one-cycle advance strobe; count freezes while en_i is low.
// Latency: tick_o is combinational, high in the cycle the count sits at TICK_DIV-1 with en_i.
// Backpressure: none; clr_i restarts the count from zero and wins over en_i.
// Ports: clk_i, reset_i (sync, active-high), en_i (count enable), clr_i (restart), tick_o.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int              PCNT_W = $clog2(TICK_DIV);
  localparam logic [PCNT_W-1:0] LAST = PCNT_W'(TICK_DIV - 1);

  logic [PCNT_W-1:0] r_pcnt;
  logic              w_last;

  assign w_last = (r_pcnt == LAST);
  assign tick_o = en_i && w_last;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pcnt <= '0;
    end else if (clr_i) begin
      r_pcnt <= '0;
    end else if (en_i) begin
      r_pcnt <= w_last ? '0 : r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/digital_clk_cfg.sv
// Real-time clock core: 1 Hz time of day with 12h/24h display, validated set, run/pause, alarm.
// Latency: display decode is zero-latency from state; tick/day_wrap/alarm/set_err pulse the cycle after their cause.
// Backpressure: none; a valid set overrides a coincident advance, a rejected set does not.
// Ports: clk_i, reset_i (sync, active-high), bus (slave side of digital_clk_cfg_if).
module digital_clk_cfg
  import clk_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter bit ALARM_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  digital_clk_cfg_if.slave   bus
);

  logic [HOUR_W-1:0] r_hour;
  logic [MIN_W-1:0]  r_min;
  logic [SEC_W-1:0]  r_sec;
  logic              r_tick;
  logic              r_day_wrap;
  logic              r_set_err;
  logic              r_alarm;

  logic              w_adv;
  logic              w_hour_ok;
  logic              w_set_ok;
  logic              w_set_load;
  logic              w_set_rej;
  logic [HOUR_W-1:0] w_set_h24;
  logic              w_sec_wrap;
  logic              w_min_wrap;
  logic              w_hour_wrap;
  logic [SEC_W-1:0]  w_nxt_sec;
  logic [MIN_W-1:0]  w_nxt_min;
  logic [HOUR_W-1:0] w_nxt_hour;
  logic              w_day_wrap;
  logic              w_alarm_hit;
  logic [HOUR_W-1:0] w_h12;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (bus.run_i),
    .clr_i   (w_set_load),   // a loaded time gets a full second before its first advance
    .tick_o  (w_adv)
  );

  // Set validation: the hour range depends on the format the user is typing in.
  assign w_hour_ok  = bus.mode_24h_i ? (bus.set_hour_i <= HOUR24_MAX)
                                     : ((bus.set_hour_i != '0) && (bus.set_hour_i <= HOUR12_MAX));
  assign w_set_ok   = w_hour_ok && (bus.set_min_i <= MIN_MAX) && (bus.set_sec_i <= SEC_MAX);
  assign w_set_load = bus.set_i && w_set_ok;
  assign w_set_rej  = bus.set_i && !w_set_ok;
  assign w_set_h24  = bus.mode_24h_i ? bus.set_hour_i : hour12_to_24(bus.set_hour_i, bus.set_pm_i);

  // Time one second ahead of the current state.
  assign w_sec_wrap  = (r_sec == SEC_MAX);
  assign w_min_wrap  = (r_min == MIN_MAX);
  assign w_hour_wrap = (r_hour == HOUR24_MAX);
  assign w_nxt_sec   = w_sec_wrap ? '0 : r_sec + 1'b1;
  assign w_nxt_min   = !w_sec_wrap ? r_min : (w_min_wrap ? '0 : r_min + 1'b1);
  assign w_nxt_hour  = !(w_sec_wrap && w_min_wrap) ? r_hour : (w_hour_wrap ? '0 : r_hour + 1'b1);
  assign w_day_wrap  = w_sec_wrap && w_min_wrap && w_hour_wrap;

  // Evaluated on the advanced time only, so a set landing on the alarm never fires it.
  // An alarm hour above 23 can never equal w_nxt_hour.
  assign w_alarm_hit = ALARM_EN && bus.alarm_en_i && (w_nxt_sec == '0)
                       && (w_nxt_min == bus.alarm_min_i) && (w_nxt_hour == bus.alarm_hour_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hour     <= '0;
      r_min      <= '0;
      r_sec      <= '0;
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_set_err  <= 1'b0;
      r_alarm    <= 1'b0;
    end else begin
      r_tick     <= 1'b0;
      r_day_wrap <= 1'b0;
      r_alarm    <= 1'b0;
      r_set_err  <= w_set_rej;
      if (w_set_load) begin
        r_hour <= w_set_h24;
        r_min  <= bus.set_min_i;
        r_sec  <= bus.set_sec_i;
      end else if (w_adv) begin
        r_hour     <= w_nxt_hour;
        r_min      <= w_nxt_min;
        r_sec      <= w_nxt_sec;
        r_tick     <= 1'b1;
        r_day_wrap <= w_day_wrap;
        r_alarm    <= w_alarm_hit;
      end
    end
  end

  // Display decode straight from state; mode only affects presentation.
  assign w_h12       = (r_hour >= HOUR12_MAX) ? r_hour - HOUR12_MAX : r_hour;
  assign bus.hour_o  = bus.mode_24h_i ? r_hour : ((w_h12 == '0) ? HOUR12_MAX : w_h12);
  assign bus.pm_o    = (r_hour >= HOUR12_MAX);
  assign bus.min_o   = r_min;
  assign bus.sec_o   = r_sec;
  assign bus.tick_o     = r_tick;
  assign bus.day_wrap_o = r_day_wrap;
  assign bus.set_err_o  = r_set_err;
  assign bus.alarm_o    = r_alarm;

endmodule
